frame_engine: RTL

Parametrised ESP32 frame parser and reply framer that sits between the UART byte interfaces and the command back-end (UID LUT or similar). It receives MAGIC|CMD|LEN|PAYLOAD|CRC frames and checks CRC in one of two selectable modes. It enforces an inter-byte timeout, dispatches validated commands over a valid/response handshake, and returns a 3-byte reply frame MAGIC|STATUS|CRC. It generalises the single-byte-reply parser with real CRC checking, bounded payload depth, timeouts and error statuses.

---
 rtl/frame_engine.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/frame_engine.sv
// Framed command parser and reply framer between the UART byte links
// and the command back-end: MAGIC|CMD|LEN|PAYLOAD|CRC in, MAGIC|STATUS|CRC out.
module frame_engine #(
   parameter int         MAX_PAYLOAD  = 16,
   parameter int         CRC_MODE     = 1,
   parameter int         BYTE_TIMEOUT = 2700000,
   parameter int         RSP_TIMEOUT  = 1024,
   parameter bit         SEND_READY   = 1'b1,
   parameter logic [7:0] FRAME_MAGIC  = 8'hA5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     rx_dv,
   input  logic [7:0]               rx_byte,
   output logic                     tx_dv,
   output logic [7:0]               tx_byte,
   input  logic                     tx_busy,
   output logic                     cmd_valid,
   output logic [7:0]               cmd_code,
   output logic [7:0]               pld_len,
   output logic [8*MAX_PAYLOAD-1:0] pld_flat,
   input  logic                     rsp_valid,
   input  logic [7:0]               rsp_code,
   output logic [15:0]              frames_ok,
   output logic [15:0]              frames_err
);

   localparam logic [7:0] READY_BYTE = 8'h52;
   localparam logic [7:0] ST_BAD_CRC = 8'hE1;
   localparam logic [7:0] ST_BAD_LEN = 8'hE2;
   localparam logic [7:0] ST_NO_RSP  = 8'hE3;
   localparam logic [7:0] MAXB       = 8'(MAX_PAYLOAD);

   localparam int BTW = $clog2(BYTE_TIMEOUT + 1);
   localparam int RTW = $clog2(RSP_TIMEOUT + 1);
   localparam logic [BTW-1:0] BT_LAST = BTW'(BYTE_TIMEOUT - 1);
   localparam logic [RTW-1:0] RT_LAST = RTW'(RSP_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_READY,
      S_IDLE,
      S_CMD,
      S_LEN,
      S_PLD,
      S_CRC,
      S_DISP,
      S_REPLY
   } state_t;

   localparam state_t S_RST = SEND_READY ? S_READY : S_IDLE;

   state_t         state;
   logic [7:0]     acc;
   logic [7:0]     cmd_r;
   logic [7:0]     len_r;
   logic [7:0]     count;
   logic [7:0]     status;
   logic [BTW-1:0] byte_tmr;
   logic [RTW-1:0] rsp_tmr;
   logic [1:0]     tx_idx;
   logic           guard;
   logic           in_frame;
   logic           byte_to;
   logic           len_zero;
   logic           len_big;
   logic [7:0]     reply_byte;

   function automatic logic [7:0] crc_step(input logic [7:0] a,
                                           input logic [7:0] b);
      logic [7:0] c;
      c = a ^ b;
      if (CRC_MODE != 0) begin
         for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
         end
      end
      return c;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign in_frame = (state == S_CMD) || (state == S_LEN) ||
                     (state == S_PLD) || (state == S_CRC);
   assign byte_to  = in_frame && !rx_dv && (byte_tmr == BT_LAST);
   assign len_zero = (rx_byte == 8'd0);
   assign len_big  = (rx_byte > MAXB);

   always_comb begin
      reply_byte = FRAME_MAGIC;
      unique case (tx_idx)
         2'd0:    reply_byte = FRAME_MAGIC;
         2'd1:    reply_byte = status;
         default: reply_byte = crc_step(8'h00, status);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_RST;
         acc        <= '0;
         cmd_r      <= '0;
         len_r      <= '0;
         count      <= '0;
         status     <= '0;
         byte_tmr   <= '0;
         rsp_tmr    <= '0;
         tx_idx     <= '0;
         guard      <= 1'b0;
         tx_dv      <= 1'b0;
         tx_byte    <= '0;
         cmd_valid  <= 1'b0;
         cmd_code   <= '0;
         pld_len    <= '0;
         pld_flat   <= '0;
         frames_ok  <= '0;
         frames_err <= '0;
      end else begin
         tx_dv     <= 1'b0;
         cmd_valid <= 1'b0;
         if (byte_to) begin
            state      <= S_IDLE;
            frames_err <= sat_inc(frames_err);
         end else begin
            if (in_frame) begin
               byte_tmr <= rx_dv ? '0 : byte_tmr + 1'b1;
            end
            case (state)
               S_READY: begin
                  if (!tx_busy) begin
                     tx_dv   <= 1'b1;
                     tx_byte <= READY_BYTE;
                     state   <= S_IDLE;
                  end
               end
               S_IDLE: begin
                  if (rx_dv && rx_byte == FRAME_MAGIC) begin
                     acc      <= '0;
                     byte_tmr <= '0;
                     state    <= S_CMD;
                  end
               end
               S_CMD: begin
                  if (rx_dv) begin
                     cmd_r <= rx_byte;
                     acc   <= crc_step(acc, rx_byte);
                     state <= S_LEN;
                  end
               end
               S_LEN: begin
                  if (rx_dv) begin
                     acc <= crc_step(acc, rx_byte);
                     unique case (1'b1)
                        len_zero: begin
                           len_r    <= '0;
                           pld_flat <= '0;
                           state    <= S_CRC;
                        end
                        len_big: begin
                           status     <= ST_BAD_LEN;
                           frames_err <= sat_inc(frames_err);
                           tx_idx     <= '0;
                           guard      <= 1'b0;
                           state      <= S_REPLY;
                        end
                        default: begin
                           len_r    <= rx_byte;
                           count    <= '0;
                           pld_flat <= '0;
                           state    <= S_PLD;
                        end
                     endcase
                  end
               end
               S_PLD: begin
                  if (rx_dv) begin
                     for (int k = 0; k < MAX_PAYLOAD; k++) begin
                        if (count == 8'(k)) pld_flat[k*8 +: 8] <= rx_byte;
                     end
                     acc   <= crc_step(acc, rx_byte);
                     count <= count + 8'd1;
                     if (count + 8'd1 == len_r) state <= S_CRC;
                  end
               end
               S_CRC: begin
                  if (rx_dv) begin
                     if (rx_byte == acc) begin
                        cmd_valid <= 1'b1;
                        cmd_code  <= cmd_r;
                        pld_len   <= len_r;
                        frames_ok <= sat_inc(frames_ok);
                        rsp_tmr   <= '0;
                        state     <= S_DISP;
                     end else begin
                        status     <= ST_BAD_CRC;
                        frames_err <= sat_inc(frames_err);
                        tx_idx     <= '0;
                        guard      <= 1'b0;
                        state      <= S_REPLY;
                     end
                  end
               end
               S_DISP: begin
                  if (rsp_valid) begin
                     status <= rsp_code;
                     tx_idx <= '0;
                     guard  <= 1'b0;
                     state  <= S_REPLY;
                  end else if (rsp_tmr == RT_LAST) begin
                     status <= ST_NO_RSP;
                     tx_idx <= '0;
                     guard  <= 1'b0;
                     state  <= S_REPLY;
                  end else begin
                     rsp_tmr <= rsp_tmr + 1'b1;
                  end
               end
               S_REPLY: begin
                  // skip the cycle after each strobe so the UART can raise busy
                  if (guard) begin
                     guard <= 1'b0;
                  end else if (!tx_busy) begin
                     tx_dv   <= 1'b1;
                     tx_byte <= reply_byte;
                     guard   <= 1'b1;
                     tx_idx  <= tx_idx + 2'd1;
                     if (tx_idx == 2'd2) state <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
